// File: rtl/minimax_wb_pkg.sv
// Shared definitions for the minimax writeback arbiter.
//   - funct3 encodings of the supported loads
//   - register-index width and the x0 constant
package minimax_wb_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/minimax_wb_fifo.sv
// Outstanding-load FIFO for the writeback arbiter.
// Each entry holds ENTRY_W bits; the destination register occupies the top
// REG_W bits so the per-entry rd can be exposed for the pending scoreboard.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   push, push_data       enqueue request (ignored when full)
//   pop, pop_data         dequeue request (ignored when empty), head entry
//   full, empty           occupancy flags
//   entry_valid, entry_rd per-slot occupancy and destination register
module minimax_wb_fifo
  import minimax_wb_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [ENTRY_W-1:0]            push_data,
  input  logic                          pop,
  output logic [ENTRY_W-1:0]            pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_W-1:0]   entry_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    entry_valid = '0;
    entry_rd    = '0;
    off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
      entry_rd[i]    = mem[i][ENTRY_W-1 -: REG_W];
    end
  end

endmodule

// File: rtl/minimax_wb_arb.sv
// Writeback arbiter and load-return stage for the minimax core.
// Merges single-cycle ALU results with load returns (loads win), tracks
// outstanding loads in a FIFO and publishes a per-register pending mask.
// Optional feature: define MINIMAX_WB_SUBWORD_EN to format LB/LH/LBU/LHU
// returns from the byte offset; otherwise every return is the full word.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_value        ALU writeback request
//   alu_stall                         ALU request refused this cycle
//   ld_issue/ld_rd/ld_funct3/ld_addr_lo  load issued to the bus
//   ld_ready                          FIFO has room for another load
//   lret_valid/lret_data              aligned load word from the bus
//   rf_addrD/rf_new_value/rf_we       registered register-file write port
//   pending                           registers awaiting load data
//   err_orphan                        sticky: return with no load queued
module minimax_wb_arb
  import minimax_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]   alu_value,
  output logic              alu_stall,
  input  logic              ld_issue,
  input  logic [REG_W-1:0]  ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  output logic              ld_ready,
  input  logic              lret_valid,
  input  logic [XLEN-1:0]   lret_data,
  output logic [REG_W-1:0]  rf_addrD,
  output logic [XLEN-1:0]   rf_new_value,
  output logic              rf_we,
  output logic [31:0]       pending,
  output logic              err_orphan
);

`ifdef MINIMAX_WB_SUBWORD_EN
  localparam int ENTRY_W = REG_W + 3 + 2;
`else
  localparam int ENTRY_W = REG_W;
`endif

  logic [ENTRY_W-1:0]              push_data;
  logic [ENTRY_W-1:0]              head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [DEPTH-1:0]                entry_valid;
  logic [DEPTH-1:0][REG_W-1:0]     entry_rd;
  logic [REG_W-1:0]                head_rd;
  logic [XLEN-1:0]                 lret_fmt;
  logic                            lret_hit;
  logic                            alu_take;

  logic                            rf_we_p1;
  logic [REG_W-1:0]                rf_addr_p1;
  logic [XLEN-1:0]                 rf_val_p1;
  logic                            err_p1;

`ifdef MINIMAX_WB_SUBWORD_EN
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      lo);
    logic [XLEN-1:0]   byte_sh;
    logic [XLEN-1:0]   half_sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    byte_sh = word >> {lo, 3'b000};
    half_sh = word >> {lo[1], 4'b0000};
    b_s     = byte_sh[7:0];
    h_s     = half_sh[15:0];
    case (f3)
      F3_LB:   fmt_load = {{(XLEN-8){b_s[7]}}, b_s};
      F3_LBU:  fmt_load = {{(XLEN-8){1'b0}}, b_s};
      F3_LH:   fmt_load = {{(XLEN-16){h_s[15]}}, h_s};
      F3_LHU:  fmt_load = {{(XLEN-16){1'b0}}, h_s};
      default: fmt_load = word;
    endcase
  endfunction

  assign push_data = {ld_rd, ld_funct3, ld_addr_lo};
  assign head_rd   = head[ENTRY_W-1 -: REG_W];
  assign lret_fmt  = fmt_load(lret_data, head[4:2], head[1:0]);
`else
  logic unused_subword;
  assign unused_subword = ^{ld_funct3, ld_addr_lo};
  assign push_data      = ld_rd;
  assign head_rd        = head;
  assign lret_fmt       = lret_data;
`endif

  minimax_wb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (ld_issue),
    .push_data   (push_data),
    .pop         (lret_valid),
    .pop_data    (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // A return only wins arbitration when it matches a queued load; orphan
  // returns are dropped and must not hold up the ALU.
  assign lret_hit  = lret_valid & ~fifo_empty;
  assign alu_stall = alu_valid & lret_hit;
  assign alu_take  = alu_valid & ~lret_hit;
  assign ld_ready  = ~fifo_full;

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_rd[i] != X0)) pending[entry_rd[i]] = 1'b1;
    end
  end

  // Stage p1: registered register-file write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_p1   <= 1'b0;
      rf_addr_p1 <= '0;
      rf_val_p1  <= '0;
      err_p1     <= 1'b0;
    end else begin
      if (lret_hit) begin
        rf_we_p1   <= (head_rd != X0);
        rf_addr_p1 <= head_rd;
        rf_val_p1  <= lret_fmt;
      end else if (alu_take) begin
        rf_we_p1   <= (alu_rd != X0);
        rf_addr_p1 <= alu_rd;
        rf_val_p1  <= alu_value;
      end else begin
        rf_we_p1   <= 1'b0;
      end
      if (lret_valid && fifo_empty) err_p1 <= 1'b1;
    end
  end

  assign rf_we        = rf_we_p1;
  assign rf_addrD     = rf_addr_p1;
  assign rf_new_value = rf_val_p1;
  assign err_orphan   = err_p1;

endmodule

// File: tb/tb_minimax_wb_arb.sv
module tb_minimax_wb_arb;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [31:0]     alu_value;
  logic            alu_stall;
  logic            ld_issue;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            ld_ready;
  logic            lret_valid;
  logic [31:0]     lret_data;
  logic [4:0]      rf_addrD;
  logic [31:0]     rf_new_value;
  logic            rf_we;
  logic [31:0]     pending;
  logic            err_orphan;

  minimax_wb_arb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_value    (alu_value),
    .alu_stall    (alu_stall),
    .ld_issue     (ld_issue),
    .ld_rd        (ld_rd),
    .ld_funct3    (ld_funct3),
    .ld_addr_lo   (ld_addr_lo),
    .ld_ready     (ld_ready),
    .lret_valid   (lret_valid),
    .lret_data    (lret_data),
    .rf_addrD     (rf_addrD),
    .rf_new_value (rf_new_value),
    .rf_we        (rf_we),
    .pending      (pending),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of outstanding loads plus expected write port.
  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_val;
  logic        m_err;

  function automatic logic [31:0] ref_fmt(input logic [31:0] d,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
`ifdef MINIMAX_WB_SUBWORD_EN
    int unsigned b, h;
    b = (d / (32'd1 << (8 * lo))) % 256;
    h = (d / (32'd1 << (16 * (lo / 2)))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? (32'hFFFF_FF00 + b) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (32'hFFFF_0000 + h) : h;
      3'b101:  return h;
      default: return d;
    endcase
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] ref_pending();
    logic [31:0] p = '0;
    foreach (q[i]) if (q[i].rd != 0) p[q[i].rd] = 1'b1;
    return p;
  endfunction

  function automatic logic ref_ready();
    return q.size() < DEPTH;
  endfunction

  function automatic logic ref_stall();
    return alu_valid && lret_valid && (q.size() > 0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_addr = 0; m_val = 0; m_err = 0;
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                        input logic li, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] lo, input logic rv, input logic [31:0] rdata);
    alu_valid = av; alu_rd = ard; alu_value = aval;
    ld_issue = li; ld_rd = lrd; ld_funct3 = f3; ld_addr_lo = lo;
    lret_valid = rv; lret_data = rdata;
    #1;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; the model applies the cycle's rules to the held inputs.
  task automatic clk_edge();
    int   sz;
    ent_t e;
    @(posedge clk);
    sz = q.size();
    if (lret_valid && sz > 0) begin
      e = q.pop_front();
      m_we = (e.rd != 0); m_addr = e.rd; m_val = ref_fmt(lret_data, e.f3, e.lo);
    end else if (alu_valid) begin
      m_we = (alu_rd != 0); m_addr = alu_rd; m_val = alu_value;
    end else begin
      m_we = 0;
    end
    if (lret_valid && sz == 0) m_err = 1;
    if (ld_issue && sz < DEPTH) begin
      e.rd = ld_rd; e.f3 = ld_funct3; e.lo = ld_addr_lo;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b want 0", rf_we); else n_pass++;
    n_checks++; if (rf_addrD !== 5'd0) $display("FAIL reset_addr: got %0d want 0", rf_addrD); else n_pass++;
    n_checks++; if (rf_new_value !== 32'd0) $display("FAIL reset_val: got %h want 0", rf_new_value); else n_pass++;
    n_checks++; if (pending !== 32'd0) $display("FAIL reset_pending: got %h want 0", pending); else n_pass++;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ld_ready); else n_pass++;
    n_checks++; if (err_orphan !== 1'b0) $display("FAIL reset_err: got %b want 0", err_orphan); else n_pass++;
    reset_n = 1;
    #1;
  endtask

  task automatic test_alu();
    set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    n_checks++; if (alu_stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", alu_stall); else n_pass++;
    clk_edge();
    n_checks++; if (rf_we !== 1'b1) $display("FAIL alu_we: got %b want 1", rf_we); else n_pass++;
    n_checks++; if (rf_addrD !== 5'd5) $display("FAIL alu_addr: got %0d want 5", rf_addrD); else n_pass++;
    n_checks++; if (rf_new_value !== 32'hDEADBEEF) $display("FAIL alu_val: got %h want deadbeef", rf_new_value); else n_pass++;
    set_in(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    clk_edge();
    n_checks++; if (rf_we !== 1'b0) $display("FAIL alu_x0_we: got %b want 0", rf_we); else n_pass++;
    idle_in();
    clk_edge();
    n_checks++; if (rf_we !== 1'b0 || rf_addrD !== 5'd0 || rf_new_value !== 32'h1234)
      $display("FAIL idle_hold: got we=%b addr=%0d val=%h want 0/0/1234", rf_we, rf_addrD, rf_new_value);
    else n_pass++;
  endtask

  task automatic test_collision();
    set_in(0, 0, 0, 1, 7, 3'b010, 0, 0, 0);
    clk_edge();
    set_in(1, 3, 32'hA5A5_0003, 0, 0, 0, 0, 1, 32'h12345678);
    n_checks++; if (pending[7] !== 1'b1) $display("FAIL col_pend_set: got %b want 1", pending[7]); else n_pass++;
    n_checks++; if (alu_stall !== 1'b1) $display("FAIL col_stall: got %b want 1", alu_stall); else n_pass++;
    clk_edge();
    n_checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd7 || rf_new_value !== 32'h12345678)
      $display("FAIL col_load_wr: got we=%b addr=%0d val=%h want 1/7/12345678", rf_we, rf_addrD, rf_new_value);
    else n_pass++;
    set_in(1, 3, 32'hA5A5_0003, 0, 0, 0, 0, 0, 0);
    n_checks++; if (pending[7] !== 1'b0) $display("FAIL col_pend_clr: got %b want 0", pending[7]); else n_pass++;
    n_checks++; if (alu_stall !== 1'b0) $display("FAIL col_unstall: got %b want 0", alu_stall); else n_pass++;
    clk_edge();
    n_checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd3 || rf_new_value !== 32'hA5A5_0003)
      $display("FAIL col_alu_wr: got we=%b addr=%0d val=%h want 1/3/a5a50003", rf_we, rf_addrD, rf_new_value);
    else n_pass++;
    idle_in();
    clk_edge();
  endtask

  task automatic test_full_same_rd();
    set_in(0, 0, 0, 1, 9, 3'b010, 0, 0, 0);
    clk_edge();
    set_in(0, 0, 0, 1, 9, 3'b010, 0, 0, 0);
    clk_edge();
    set_in(0, 0, 0, 1, 11, 3'b010, 0, 0, 0);   // issued while full: dropped
    n_checks++; if (ld_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", ld_ready); else n_pass++;
    n_checks++; if (pending[9] !== 1'b1) $display("FAIL full_pend9: got %b want 1", pending[9]); else n_pass++;
    clk_edge();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0009);
    n_checks++; if (pending[11] !== 1'b0) $display("FAIL full_drop: got %b want 0", pending[11]); else n_pass++;
    clk_edge();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0019);
    n_checks++; if (pending[9] !== 1'b1) $display("FAIL full_pend9_one: got %b want 1", pending[9]); else n_pass++;
    clk_edge();
    idle_in();
    n_checks++; if (pending[9] !== 1'b0) $display("FAIL full_pend9_clr: got %b want 0", pending[9]); else n_pass++;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL full_ready_back: got %b want 1", ld_ready); else n_pass++;
    n_checks++; if (rf_addrD !== 5'd9 || rf_new_value !== 32'h19)
      $display("FAIL full_second_wr: got addr=%0d val=%h want 9/19", rf_addrD, rf_new_value);
    else n_pass++;
    clk_edge();
  endtask

  task automatic test_orphan();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    clk_edge();
    n_checks++; if (rf_we !== 1'b0) $display("FAIL orphan_we: got %b want 0", rf_we); else n_pass++;
    n_checks++; if (err_orphan !== 1'b1) $display("FAIL orphan_err: got %b want 1", err_orphan); else n_pass++;
    set_in(1, 4, 32'h44, 0, 0, 0, 0, 1, 32'hBAD1);
    n_checks++; if (alu_stall !== 1'b0) $display("FAIL orphan_nostall: got %b want 0", alu_stall); else n_pass++;
    clk_edge();
    n_checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd4 || rf_new_value !== 32'h44)
      $display("FAIL orphan_alu_wr: got we=%b addr=%0d val=%h want 1/4/44", rf_we, rf_addrD, rf_new_value);
    else n_pass++;
    idle_in();
    repeat (3) clk_edge();
    n_checks++; if (err_orphan !== 1'b1) $display("FAIL orphan_sticky: got %b want 1", err_orphan); else n_pass++;
  endtask

  task automatic test_subword();
    logic [31:0] exp_v [3];
    logic [2:0]  f3s   [3];
    logic [1:0]  los   [3];
    logic [31:0] dat   [3];
    f3s[0] = 3'b000; los[0] = 3; dat[0] = 32'h80FFFFFF;
    f3s[1] = 3'b100; los[1] = 3; dat[1] = 32'h80FFFFFF;
    f3s[2] = 3'b001; los[2] = 2; dat[2] = 32'h7FFF0000;
`ifdef MINIMAX_WB_SUBWORD_EN
    exp_v[0] = 32'hFFFFFF80; exp_v[1] = 32'h00000080; exp_v[2] = 32'h00007FFF;
`else
    exp_v[0] = 32'h80FFFFFF; exp_v[1] = 32'h80FFFFFF; exp_v[2] = 32'h7FFF0000;
`endif
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 1, 5'd10, f3s[i], los[i], 0, 0);
      clk_edge();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, dat[i]);
      clk_edge();
      n_checks++; if (rf_we !== 1'b1 || rf_new_value !== exp_v[i])
        $display("FAIL subword_%0d: got we=%b val=%h want 1/%h", i, rf_we, rf_new_value, exp_v[i]);
      else n_pass++;
    end
    idle_in();
    clk_edge();
  endtask

  task automatic test_random();
    logic iss, ret;
    for (int c = 0; c < 400; c++) begin
      iss = ($urandom_range(0, 99) < 45);
      ret = (q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3);
      set_in($urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)), $urandom,
             iss, 5'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             ret, $urandom);
      n_checks++; if (alu_stall !== ref_stall() || ld_ready !== ref_ready() || pending !== ref_pending())
        $display("FAIL rand_comb c%0d: got stall=%b ready=%b pend=%h want %b/%b/%h",
                 c, alu_stall, ld_ready, pending, ref_stall(), ref_ready(), ref_pending());
      else n_pass++;
      clk_edge();
      n_checks++; if (rf_we !== m_we || rf_addrD !== m_addr || rf_new_value !== m_val || err_orphan !== m_err)
        $display("FAIL rand_wr c%0d: got we=%b addr=%0d val=%h err=%b want %b/%0d/%h/%b",
                 c, rf_we, rf_addrD, rf_new_value, err_orphan, m_we, m_addr, m_val, m_err);
      else n_pass++;
    end
    idle_in();
    clk_edge();
  endtask

  task automatic test_reset_mid();
    set_in(0, 0, 0, 1, 12, 3'b010, 0, 0, 0);
    clk_edge();
    set_in(1, 6, 32'h66, 1, 13, 3'b010, 0, 0, 0);
    clk_edge();
    idle_in();
    n_checks++; if (pending[13:12] !== 2'b11 || rf_we !== 1'b1)
      $display("FAIL mid_pre: got pend=%b we=%b want 11/1", pending[13:12], rf_we);
    else n_pass++;
    #2;
    reset_n = 0;
    model_reset();
    #1;
    n_checks++; if (pending !== 32'd0) $display("FAIL mid_pending: got %h want 0", pending); else n_pass++;
    n_checks++; if (rf_we !== 1'b0) $display("FAIL mid_we: got %b want 0", rf_we); else n_pass++;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", ld_ready); else n_pass++;
    n_checks++; if (err_orphan !== 1'b0) $display("FAIL mid_err: got %b want 0", err_orphan); else n_pass++;
    @(posedge clk);
    #1;
    reset_n = 1;
    #1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_collision();
    test_full_same_rd();
    test_orphan();
    test_subword();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/minimax_wb_arb.md
Name: minimax_wb_arb

Overview:
- Writeback arbiter and load-return stage.
- Sits directly upstream of the register file write port and drives its destination address, write data and write enable.
- Merges single-cycle ALU results with out-of-order-in-time load returns from the data bus.
- Tracks outstanding loads in a small FIFO and publishes a per-register pending scoreboard, so the core stalls reads of registers still awaiting load data.

Parameters:
- DEPTH, 2: maximum outstanding loads; power of two, minimum 2.
- XLEN, 32: data width.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result ready for writeback this cycle.
- alu_rd  in  5  ALU destination register.
- alu_value  in  XLEN  ALU result.
- alu_stall  out  1  ALU request not accepted this cycle; core holds it.
- ld_issue  in  1  load issued to the bus this cycle.
- ld_rd  in  5  load destination register.
- ld_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ld_addr_lo  in  2  byte offset of the load address.
- ld_ready  out  1  FIFO can accept a load.
- lret_valid  in  1  bus returns the aligned load word.
- lret_data  in  XLEN  returned word.
- rf_addrD  out  5  register file write address.
- rf_new_value  out  XLEN  register file write data.
- rf_we  out  1  register file write enable.
- pending  out  32  bit r set while any queued load targets xr; bit 0 is always 0.
- err_orphan  out  1  sticky flag: a load return arrived with no load queued.

Behaviour:
- Reset (async, reset_n=0): FIFO empty; rf_we=0; rf_addrD=0; rf_new_value=0; err_orphan=0. Consequently pending=0 and ld_ready=1.
- Latency: rf_* outputs are registered, one cycle after the accepted source. The register file then commits on the following edge.
- Arbitration: a load return has priority.
  - alu_stall = alu_valid & lret_valid & FIFO nonempty (combinational).
  - A stalled ALU request is not captured.
- Load return with FIFO nonempty:
  - Pop the head entry (rd, funct3, addr_lo) and format the data (see Optional Feature).
  - Next cycle: rf_we = (rd != 0), rf_addrD = rd, rf_new_value = formatted value.
- Load return with FIFO empty: data dropped, err_orphan set until reset. The ALU is not stalled and proceeds normally that cycle.
- ALU accepted: next cycle rf_we = (alu_rd != 0), rf_addrD = alu_rd, rf_new_value = alu_value.
- Idle cycle: rf_we=0; rf_addrD and rf_new_value hold their previous values.
- ld_issue: push {ld_rd, ld_funct3, ld_addr_lo} when ld_ready.
  - ld_ready = !full. Computed from the current count only; no credit is taken for a same-cycle pop.
  - ld_issue while !ld_ready is a protocol violation; the entry is dropped and the FIFO state is unchanged.
- Same-cycle push and pop: both occur; count unchanged; pointers wrap modulo DEPTH.
- pending[r] is combinational: OR over valid FIFO entries whose rd==r, for r≠0.
  - With two queued loads to the same rd, the bit stays set until both have popped.
  - A load to x0 is queued and consumes a slot but never sets a pending bit or writes.
- WAW between an ALU write and a pending load to the same rd is not checked here; the core stalls on pending.

Optional Feature:
- Macro: MINIMAX_WB_SUBWORD_EN.
- Defined:
  - FIFO entries store funct3 and addr_lo.
  - Byte lane = lret_data >> (8*addr_lo); halfword lane = lret_data >> (16*addr_lo[1]).
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - Any other funct3 value is treated as LW.
- Undefined:
  - funct3 and addr_lo are not stored.
  - Every return is written as the full word, unmodified.

Decomposition:
- Shared package holds: funct3 load encodings (LB/LH/LW/LBU/LHU), the register-index width (5), and the x0 constant.
- One natural sub-module, minimax_wb_fifo: a parameterised DEPTH-entry FIFO with push, pop, full, empty and an entry-valid vector plus per-entry rd exposed for the scoreboard.
- Formatting and arbitration stay in the top module.

Test Plan:
- Reset mid-operation: two loads queued, then reset_n=0 → pending=0, rf_we=0, ld_ready=1 immediately, without waiting for a clock edge.
- ALU only: alu_valid=1, alu_rd=5, alu_value=0xDEADBEEF → next cycle rf_we=1, rf_addrD=5, rf_new_value=0xDEADBEEF. Repeat with alu_rd=0 → rf_we=0.
- Collision: load to x7 queued; lret_valid=1 (data 0x12345678) together with alu_valid=1 (x3) → alu_stall=1. Next cycle writes x7=0x12345678, pending[7] clears, and the ALU write to x3 lands one cycle later.
- FIFO full and same-rd loads: issue two loads to x9 → ld_ready=0 and pending[9]=1. First return → pending[9] still 1. Second return → pending[9]=0, ld_ready=1.
- Orphan return: lret_valid with FIFO empty → no write and err_orphan=1, held until reset.
- Subword (macro on): LB with addr_lo=3, data 0x80FFFFFF → 0xFFFFFF80. LBU, same inputs → 0x00000080. LH with addr_lo=2, data 0x7FFF0000 → 0x00007FFF. With the macro off, the same returns write 0x80FFFFFF and 0x7FFF0000 respectively.
